// File: rtl/pipe_stage_reg.sv
`default_nettype none
// =============================================================================
// pipe_stage_reg : valid/ready pipeline stage register with flush, saturating
//                  stall counter and optional 2-entry skid buffer (PIPE_SKID_EN).
// Rev 1.0
// =============================================================================
module pipe_stage_reg #(
   parameter int unsigned       DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  hold_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             w_accept;
   logic             w_emit;
   logic             w_stall;
   logic [CNT_W-1:0] r_hold_cnt;

   assign w_accept = in_valid & in_ready;
   assign w_emit   = out_valid & out_ready;
   assign w_stall  = out_valid & ~out_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
      end else if (w_stall && (r_hold_cnt != c_CNT_MAX)) begin
         r_hold_cnt <= r_hold_cnt + c_CNT_ONE;
      end
   end

   assign hold_cnt = r_hold_cnt;

`ifdef PIPE_SKID_EN
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_FULL  = 2'd1;
   localparam logic [1:0] S_SKID  = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] r_main_data;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_load_main_in;
   logic              w_load_main_skid;
   logic              w_load_skid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL: begin
               if (w_accept && !w_emit)      w_state_nxt = S_SKID;
               else if (w_emit && !w_accept) w_state_nxt = S_EMPTY;
            end
            S_SKID:  if (w_emit) w_state_nxt = S_FULL;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Ready comes from the state flop only, so out_ready never reaches in_ready.
   always_comb begin
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (!flush) begin
         case (r_state)
            S_EMPTY: w_load_main_in = w_accept;
            S_FULL: begin
               w_load_main_in = w_accept & w_emit;
               w_load_skid    = w_accept & ~w_emit;
            end
            S_SKID:  w_load_main_skid = w_emit;
            default: begin
               w_load_main_in   = 1'b0;
               w_load_main_skid = 1'b0;
               w_load_skid      = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_data <= NOP_VALUE;
         r_skid_data <= NOP_VALUE;
      end else if (flush) begin
         r_main_data <= NOP_VALUE;
         r_skid_data <= NOP_VALUE;
      end else begin
         if (w_load_main_in) begin
            r_main_data <= in_data;
         end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
         end
      end
   end

   assign in_ready  = (r_state != S_SKID);
   assign out_valid = (r_state != S_EMPTY);
   assign out_data  = r_main_data;
`else
   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // A simultaneous emit and accept falls into the accept branch: no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= NOP_VALUE;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_data  <= NOP_VALUE;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= in_data;
      end else if (w_emit) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready  = ~r_valid | out_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg (both PIPE_SKID_EN builds);
// a second small instance exercises hold_cnt saturation.
module tb_pipe_stage_reg;

   localparam int unsigned       DATA_W = 64;
   localparam logic [DATA_W-1:0] NOP    = 64'h0000_0000_0000_0013;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              flush     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data   = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [15:0]       hold_cnt;

   logic              s_in_valid  = 1'b0;
   logic              s_in_ready;
   logic [7:0]        s_in_data   = '0;
   logic              s_out_valid;
   logic              s_out_ready = 1'b0;
   logic [7:0]        s_out_data;
   logic [2:0]        s_hold_cnt;
   logic              s_flush     = 1'b0;

   int                checks   = 0;
   int                failures = 0;
   int                emitted  = 0;
   logic [DATA_W-1:0] sb_q[$];
   logic [DATA_W-1:0] exp_d;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_stall = 1'b0;
   logic              model_rdy;

   pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .hold_cnt(hold_cnt)
   );

   pipe_stage_reg #(.DATA_W(8), .NOP_VALUE(8'h00), .CNT_W(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .hold_cnt(s_hold_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL reset_data: got %h want %h", out_data, NOP); end
      checks++; if (hold_cnt !== 16'd0) begin failures++; $display("FAIL reset_hold: got %0d want 0", hold_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77;
      s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrun_valid: got %b want 1", out_valid); end
      checks++; if (hold_cnt !== 16'd2) begin failures++; $display("FAIL midrun_hold: got %0d want 2", hold_cnt); end
      checks++; if (s_hold_cnt !== 3'd2) begin failures++; $display("FAIL midrun_sat_hold: got %0d want 2", s_hold_cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL async_data: got %h want %h", out_data, NOP); end
      checks++; if (hold_cnt !== 16'd0) begin failures++; $display("FAIL async_hold: got %0d want 0", hold_cnt); end
      checks++; if (s_hold_cnt !== 3'd0) begin failures++; $display("FAIL async_sat_hold: got %0d want 0", s_hold_cnt); end
      in_valid = 1'b0; s_in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_stream;
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = DATA_W'(i);
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (out_data !== DATA_W'(i)) begin failures++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, DATA_W'(i)); end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain: got %b want 0", out_valid); end
      checks++; if (out_data !== DATA_W'(8)) begin failures++; $display("FAIL stream_keep: got %h want 8", out_data); end
      checks++; if (hold_cnt !== 16'd0) begin failures++; $display("FAIL stream_hold: got %0d want 0", hold_cnt); end
   endtask

   task automatic test_stall;
      do_reset();
      in_valid = 1'b1; in_data = 64'hA;
      s_in_valid = 1'b1; s_in_data = 8'hA5;
      @(posedge clk); #1;
      in_valid = 1'b0; s_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (out_data !== 64'hA || out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/a", i, out_valid, out_data); end
      end
      checks++; if (hold_cnt !== 16'd5) begin failures++; $display("FAIL stall_cnt: got %0d want 5", hold_cnt); end
      checks++; if (s_hold_cnt !== 3'd5) begin failures++; $display("FAIL sat_cnt5: got %0d want 5", s_hold_cnt); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (s_hold_cnt !== 3'd7) begin failures++; $display("FAIL sat_cnt: got %0d want 7", s_hold_cnt); end
      checks++; if (s_out_data !== 8'hA5) begin failures++; $display("FAIL sat_data: got %h want a5", s_out_data); end
      checks++; if (hold_cnt !== 16'd10) begin failures++; $display("FAIL stall_cnt10: got %0d want 10", hold_cnt); end
      out_ready = 1'b1; s_out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_emit: got %b want 0", out_valid); end
      checks++; if (out_data !== 64'hA) begin failures++; $display("FAIL stall_keep: got %h want a", out_data); end
      checks++; if (hold_cnt !== 16'd10) begin failures++; $display("FAIL stall_cnt_after: got %0d want 10", hold_cnt); end
   endtask

   task automatic test_flush;
      do_reset();
      in_valid = 1'b1; in_data = 64'h11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hB;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== NOP) begin failures++; $display("FAIL flush_data: got %h want %h", out_data, NOP); end
      checks++; if (hold_cnt !== 16'd2) begin failures++; $display("FAIL flush_hold: got %0d want 2", hold_cnt); end
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hE;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin failures++; $display("FAIL flush_empty: got %b/%h want 0/%h", out_valid, out_data, NOP); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d]: got %b want 0", i, out_valid); end
      end
   endtask

`ifdef PIPE_SKID_EN
   task automatic test_skid;
      do_reset();
      in_valid = 1'b1; in_data = 64'hC;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_full: got %b want 1", in_ready); end
      in_data = 64'hD;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_skid: got %b want 0", in_ready); end
      in_data = 64'hE;
      @(posedge clk); #1;
      checks++; if (out_data !== 64'hC || in_ready !== 1'b0) begin failures++; $display("FAIL skid_hold: got %h/%b want c/0", out_data, in_ready); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 64'hD) begin failures++; $display("FAIL skid_second: got %b/%h want 1/d", out_valid, out_data); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back: got %b want 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_drain: got %b want 0", out_valid); end
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h21;
      @(posedge clk); #1 in_data = 64'h22;
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== NOP) begin failures++; $display("FAIL skid_flush: got %b/%b/%h want 0/1/%h", out_valid, in_ready, out_data, NOP); end
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h23;
      @(posedge clk); #1 in_valid = 1'b0;
      checks++; if (out_data !== 64'h23) begin failures++; $display("FAIL skid_after_flush: got %h want 23", out_data); end
   endtask
`else
   task automatic test_ready_path;
      do_reset();
      in_valid = 1'b1; in_data = 64'h31;
      @(posedge clk); #1;
      in_data = 64'h32;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL comb_ready_low: got %b want 0", in_ready); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL comb_ready_high: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 64'h32) begin failures++; $display("FAIL no_bubble: got %b/%h want 1/32", out_valid, out_data); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ready_drain: got %b want 0", out_valid); end
   endtask
`endif

   task automatic test_random;
      int e0;
      do_reset();
      e0 = emitted;
      for (int i = 0; i < 1000; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = {$urandom(), $urandom()};
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 31) == 0);
         @(posedge clk); #1;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL rand_leftover: got %0d want 0", sb_q.size()); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_idle: got %b want 0", out_valid); end
      checks++; if (emitted - e0 < 100) begin failures++; $display("FAIL rand_volume: got %0d want >=100", emitted - e0); end
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               sb_q.delete();
               prev_stall = 1'b0;
            end else begin
`ifdef PIPE_SKID_EN
               model_rdy = (sb_q.size() < 2);
`else
               model_rdy = (sb_q.size() == 0) || out_ready;
`endif
               checks++; if (in_ready !== model_rdy) begin failures++; $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, model_rdy, $time); end
               checks++; if (out_valid !== (sb_q.size() != 0)) begin failures++; $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, sb_q.size() != 0, $time); end
               if (prev_stall) begin
                  checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin failures++; $display("FAIL sb_stable: got %b/%h want 1/%h at %0t", out_valid, out_data, prev_data, $time); end
               end
               if (flush) begin
                  sb_q.delete();
               end else begin
                  if ((sb_q.size() != 0) && out_ready) begin
                     exp_d = sb_q.pop_front();
                     emitted++;
                     checks++; if (out_data !== exp_d) begin failures++; $display("FAIL sb_data: got %h want %h at %0t", out_data, exp_d, $time); end
                  end
                  if (in_valid && model_rdy) sb_q.push_back(in_data);
               end
               prev_stall = out_valid && !out_ready && !flush;
               prev_data  = out_data;
            end
         end
      join_none
      test_reset();
      test_stream();
      test_stall();
      test_flush();
`ifdef PIPE_SKID_EN
      test_skid();
`else
      test_ready_path();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
